// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : serial_adder_pkg

// File: rtl/half_adder.sv
// One-bit half adder; two of these plus an OR form the serial adder's full-add cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : half_adder

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one operand bit per SHIFT cycle, result in WIDTH cycles.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] suma,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             acarreo
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   suma_q, suma_d;
    logic               acarreo_q, acarreo_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic bit_sum, bit_cout, ha0_s, ha0_c, ha1_c;

    half_adder u_ha_ops (
        .a (op_a_q[0]),
        .b (op_b_q[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder u_ha_carry (
        .a (ha0_s),
        .b (carry_q),
        .s (bit_sum),
        .c (ha1_c)
    );

    assign bit_cout = ha0_c | ha1_c;

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        part_d    = part_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        suma_d    = suma_q;
        acarreo_d = acarreo_q;
`ifdef SERIAL_ADDER_OVF_EN
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            // The done cycle's closing edge doubles as the earliest acceptance
            // edge, so results can be issued back-to-back every WIDTH+1 cycles.
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = SHIFT;
                    op_a_d  = a;
                    op_b_d  = b;
                    part_d  = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            SHIFT: begin
                part_d  = {bit_sum, part_q[WIDTH-1:1]};
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                carry_d = bit_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d   = DONE;
                    suma_d    = {bit_sum, part_q[WIDTH-1:1]};
                    acarreo_d = bit_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d     = (a_msb_q == b_msb_q) && (bit_sum != a_msb_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            part_q    <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            suma_q    <= '0;
            acarreo_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            part_q    <= part_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            suma_q    <= suma_d;
            acarreo_q <= acarreo_d;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign suma    = suma_q;
    assign acarreo = acarreo_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed scenarios plus random sums vs a+b.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, acarreo;
    logic [W-1:0] suma;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
    logic         last_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    // Model of the held result registers.
    logic [W-1:0] last_sum;
    logic         last_carry;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .suma    (suma),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf     (ovf),
`endif
        .acarreo (acarreo)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_held(input string tag);
        check_eq({tag, "_suma_held"}, 32'(suma), 32'(last_sum));
        check_eq({tag, "_carry_held"}, 32'(acarreo), 32'(last_carry));
`ifdef SERIAL_ADDER_OVF_EN
        check_eq({tag, "_ovf_held"}, 32'(ovf), 32'(last_ovf));
`endif
    endtask

    // Called at a negedge. Runs one sum; optionally pokes start mid-sum.
    // With chain=1 it returns in the done cycle so the next call starts on the done edge.
    task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input bit poke, input bit chain);
        logic [W:0] total;
        logic       exp_ovf;
        int         s_ta, s_tb, s_sum;
        total   = {1'b0, ta} + {1'b0, tb};
        s_ta    = int'($signed(ta));
        s_tb    = int'($signed(tb));
        s_sum   = s_ta + s_tb;
        exp_ovf = (s_sum > 127) || (s_sum < -128);
        start = 1'b1;
        a     = ta;
        b     = tb;
        @(posedge clk);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            check_eq($sformatf("busy_c%0d", i), 32'(busy), 32'd1);
            check_eq($sformatf("done_c%0d", i), 32'(done), 32'd0);
            check_held($sformatf("shift_c%0d", i));
            start = (poke && i == 3);
            a     = W'($urandom);
            b     = W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("busy_in_done", 32'(busy), 32'd0);
        check_eq("suma", 32'(suma), 32'(total[W-1:0]));
        check_eq("acarreo", 32'(acarreo), 32'(total[W]));
`ifdef SERIAL_ADDER_OVF_EN
        check_eq("ovf", 32'(ovf), 32'(exp_ovf));
        last_ovf = exp_ovf;
`endif
        last_sum   = total[W-1:0];
        last_carry = total[W];
        $display("txn a=0x%02h b=0x%02h -> suma=0x%02h acarreo=%0d exp=0x%03h poke=%0d chain=%0d ovf_exp=%0d",
                 ta, tb, suma, acarreo, total, poke, chain, exp_ovf);
        if (!chain) begin
            @(negedge clk);
            check_eq("done_one_cycle", 32'(done), 32'd0);
            check_eq("idle_after_done", 32'(busy), 32'd0);
            check_held("after_done");
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        a          = '0;
        b          = '0;
        last_sum   = '0;
        last_carry = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        last_ovf   = 1'b0;
`endif
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_held("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed scenarios.
        txn(8'h00, 8'h00, 1'b0, 1'b0);
        txn(8'hFF, 8'h01, 1'b0, 1'b0);
        txn(8'hA5, 8'h5A, 1'b0, 1'b0);
        txn(8'h11, 8'h22, 1'b1, 1'b0);
        txn(8'h01, 8'h01, 1'b0, 1'b1);
        txn(8'h80, 8'h80, 1'b0, 1'b0);
        txn(8'h7F, 8'h01, 1'b0, 1'b0);
        txn(8'hFF, 8'h01, 1'b0, 1'b0);
        txn(8'hC3, 8'h5A, 1'b0, 1'b0);

        // Reset during SHIFT cycle 4 clears everything at once.
        start = 1'b1;
        a     = 8'h33;
        b     = 8'h44;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        last_sum   = '0;
        last_carry = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        last_ovf   = 1'b0;
`endif
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        check_held("midrst");
        @(negedge clk);
        check_eq("rst_hold_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        txn(8'h10, 8'h20, 1'b0, 1'b0);

        // Random sums, some issued back-to-back on the done edge.
        for (int n = 0; n < 24; n++) begin
            txn(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)));
        end
        @(negedge clk);
        @(negedge clk);
        check_eq("final_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_adder
